// File: rtl/pixel_stream_source_pkg.sv
// pixel_stream_source_pkg: default frame geometry, sample width and stream FSM encoding
package pixel_stream_source_pkg;
    localparam int DEF_IMG_WIDTH  = 14;
    localparam int DEF_IMG_HEIGHT = 14;
    localparam int DEF_DATAWIDTH  = 32;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINISH = 2'd2
    } state_t;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pixel_frame_ram.sv
// pixel_frame_ram: single write port, registered read port; only the read register is reset
module pixel_frame_ram #(
    parameter int DEPTH = 196,
    parameter int WIDTH = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // rdata holds between reads so the stream outputs keep their last pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/pixel_stream_source.sv
// pixel_stream_source: loads a frame while idle, then streams it in raster order
// with sof/eol/eof markers, downstream stall and a one-cycle done pulse.
module pixel_stream_source
    import pixel_stream_source_pkg::*;
#(
    parameter int IMG_Width  = DEF_IMG_WIDTH,
    parameter int IMG_Height = DEF_IMG_HEIGHT,
    parameter int Datawidth  = DEF_DATAWIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_en,
    input  logic [$clog2(IMG_Width*IMG_Height)-1:0] wr_addr,
    input  logic [Datawidth-1:0]                    wr_data0,
    input  logic [Datawidth-1:0]                    wr_data1,
    input  logic [Datawidth-1:0]                    wr_data2,
    input  logic                                    start,
    input  logic                                    stall,
    output logic                                    valid_out,
    output logic [Datawidth-1:0]                    Out_0,
    output logic [Datawidth-1:0]                    Out_1,
    output logic [Datawidth-1:0]                    Out_2,
    output logic                                    sof,
    output logic                                    eol,
    output logic                                    eof,
    output logic                                    busy,
    output logic                                    done
);
    localparam int NPIX = IMG_Width * IMG_Height;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = cnt_w(IMG_Width);
    localparam int RW   = cnt_w(IMG_Height);

    state_t          state, state_nxt;
    logic [AW-1:0]   idx;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            issue, last, col_end, wr_ok;

    assign issue   = (state == S_STREAM) && !stall;
    assign last    = idx == AW'(NPIX - 1);
    assign col_end = col == CW'(IMG_Width - 1);
    assign wr_ok   = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < (AW+1)'(NPIX));

    always_comb begin
        state_nxt = state;
        busy      = state != S_IDLE;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_STREAM;
            S_STREAM: if (issue && last) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // markers are registered with the read so they line up with the RAM data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            col       <= '0;
            row       <= '0;
            valid_out <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            valid_out <= issue;
            sof       <= issue && (idx == '0);
            eol       <= issue && col_end;
            eof       <= issue && last;
            done      <= state == S_FINISH;
            if (state == S_IDLE && start) begin
                idx <= '0;
                col <= '0;
                row <= '0;
            end else if (issue) begin
                idx <= last ? idx : idx + 1'b1;
                col <= col_end ? '0 : col + 1'b1;
                row <= (col_end && row != RW'(IMG_Height - 1)) ? row + 1'b1 : row;
            end
        end
    end

    pixel_frame_ram #(
        .DEPTH (NPIX),
        .WIDTH (3 * Datawidth),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata ({wr_data2, wr_data1, wr_data0}),
        .re    (issue),
        .raddr (idx),
        .rdata ({Out_2, Out_1, Out_0})
    );
endmodule
